// File: rtl/risc_dm_arbiter.sv
// Arbiter sharing the single-port 16x8 data memory between the core's execute-stage port
// and a host/debug port. Optional ARB_STATS_EN adds stall and forced-grant counters.
module risc_dm_arbiter #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_en,
  input  logic              core_rdwr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_lock,
  input  logic              host_rdwr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef ARB_STATS_EN
  output logic [15:0]       stall_cnt,
  output logic [7:0]        force_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_CORE, S_HOST, S_LOCK, S_REL} state_e;

  localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  state_e            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_host_q, rd_host_d;
  logic [DATA_W-1:0] core_rdata_q, host_rdata_q;
  logic              core_win, host_win, forced;
  logic              core_rv, host_rv;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    core_win = 1'b0;
    host_win = 1'b0;
    forced   = 1'b0;
    unique case (state_q)
      S_LOCK: host_win = host_req;
      S_REL: begin
        core_win = core_en;
        host_win = host_req & ~core_en;
      end
      default: begin
        if (core_en && host_req) begin
          if (wait_cnt_q == WAIT_MAX) begin
            host_win = 1'b1;
            forced   = 1'b1;
          end else begin
            core_win = 1'b1;
          end
        end else begin
          core_win = core_en;
          host_win = host_req;
        end
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    if (state_q == S_LOCK) begin
      if (host_win) burst_cnt_d = burst_cnt_q + 4'd1;
      if (!host_lock || !host_req || burst_cnt_d == BURST_MAX) begin
        state_d     = S_REL;
        burst_cnt_d = 4'd0;
      end
    end else if (core_win) begin
      state_d = S_CORE;
    end else if (host_win && host_lock) begin
      // The entry grant is the first beat of the burst.
      burst_cnt_d = 4'd1;
      state_d     = (BURST_MAX == 4'd1) ? S_REL : S_LOCK;
    end else if (host_win) begin
      state_d = S_HOST;
    end else begin
      state_d = S_IDLE;
    end

    if (!host_req || host_win)     wait_cnt_d = 4'd0;
    else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 4'd1;
    else                           wait_cnt_d = wait_cnt_q;

    rd_vld_d  = (core_win & core_rdwr) | (host_win & host_rdwr);
    rd_host_d = host_win & host_rdwr;
  end

  assign core_rv = rd_vld_q & ~rd_host_q;
  assign host_rv = rd_vld_q & rd_host_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= 4'd0;
      burst_cnt_q  <= 4'd0;
      rd_vld_q     <= 1'b0;
      rd_host_q    <= 1'b0;
      core_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      rd_vld_q    <= rd_vld_d;
      rd_host_q   <= rd_host_d;
      if (core_rv) core_rdata_q <= mem_rdata;
      if (host_rv) host_rdata_q <= mem_rdata;
    end
  end

  // Every output is forced low while reset is asserted, combinational ones included.
  always_comb begin
    core_stall  = rst_n & core_en & ~core_win;
    host_gnt    = rst_n & host_win;
    core_rvalid = rst_n & core_rv;
    host_rvalid = rst_n & host_rv;
    core_rdata  = '0;
    host_rdata  = '0;
    mem_en      = rst_n & (core_win | host_win);
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (rst_n) begin
      core_rdata = core_rv ? mem_rdata : core_rdata_q;
      host_rdata = host_rv ? mem_rdata : host_rdata_q;
      if (core_win) begin
        mem_we    = ~core_rdwr;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
      end else if (host_win) begin
        mem_we    = ~host_rdwr;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [7:0]  force_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      force_cnt_q <= '0;
    end else begin
      if (core_stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (forced && force_cnt_q != 8'hFF)        force_cnt_q <= force_cnt_q + 8'd1;
    end
  end

  assign stall_cnt = rst_n ? stall_cnt_q : 16'd0;
  assign force_cnt = rst_n ? force_cnt_q : 8'd0;
`endif

endmodule

// File: doc/risc_dm_arbiter.md
Name: risc_dm_arbiter

Overview:
Shares the single-port 16x8 data memory between two requesters: the RISC pipeline's execution-stage memory port and a host/debug port used for memory load and inspection. The core has default priority. A wait counter prevents host starvation, and a bounded host lock mode supports bursts. When the core loses arbitration, a stall is returned to the pipeline. The block sits between the execution unit outputs (dmenbl, rdwr, dmaddr, dmdatain) and the data memory macro.

Parameters:
ADDR_W, 4, memory address width
DATA_W, 8, memory data width
MAX_WAIT, 4, number of consecutive host-denied cycles before the host is forced to win (1..15)
MAX_BURST, 8, maximum consecutive locked host grants before a forced release (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
core_en  in  1  core memory request (from execution-unit dmenbl)
core_rdwr  in  1  1 = read, 0 = write
core_addr  in  ADDR_W  core address
core_wdata  in  DATA_W  core write data
core_stall  out  1  core request denied this cycle; pipeline holds
core_rvalid  out  1  core read data valid
core_rdata  out  DATA_W  core read data
host_req  in  1  host request
host_lock  in  1  host requests burst ownership
host_rdwr  in  1  1 = read, 0 = write
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  host access accepted this cycle
host_rvalid  out  1  host read data valid
host_rdata  out  DATA_W  host read data
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after a mem_en read

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; wait_cnt, burst_cnt and rd_owner clear.
  - All outputs read 0 while rst_n is low, including combinational outputs.
  - Reset mid-burst or mid-read drops the pending rvalid.
- FSM states:
  - IDLE: no request.
  - CORE: core owns the current cycle.
  - HOST: host owns the current cycle, unlocked.
  - LOCK: host burst in progress.
  - REL: forced one-cycle release after a burst.
- Arbitration is combinational in the current cycle.
  - IDLE/CORE/HOST states:
    - Only one requester active: that requester wins.
    - Both active: core wins, unless wait_cnt == MAX_WAIT, in which case the host wins.
  - LOCK: host wins every cycle while host_req is 1. The core is stalled.
  - REL: core wins whenever core_en is 1. The host wins only if core_en is 0.
- Grant, stall and memory outputs:
  - host_gnt = host wins.
  - core_stall = core_en & ~(core wins).
  - mem_en = core_en | host_req granted.
  - mem_we = ~rdwr of the winner.
  - mem_addr and mem_wdata are muxed from the winner; they are 0 when there is no winner.
- Next state:
  - Core win -> CORE.
  - Host win with host_lock = 1 -> LOCK, burst_cnt = 1.
  - Host win otherwise -> HOST.
  - No request -> IDLE.
- LOCK:
  - burst_cnt increments on each grant.
  - Exits to REL when host_lock = 0, host_req = 0, or burst_cnt == MAX_BURST after the grant.
  - REL lasts exactly 1 cycle.
- wait_cnt:
  - Increments when host_req & ~host_gnt; saturates at MAX_WAIT.
  - Clears on host_gnt or when host_req = 0.
- Read return:
  - A granted read registers rd_owner (core or host).
  - The next cycle, the matching rvalid pulses for 1 cycle and its rdata = mem_rdata.
  - Non-matching rdata holds its last value.
  - Back-to-back reads from alternating owners each return correctly.
- Writes complete in the grant cycle; no response is returned.
- Host contract: host must hold req, addr, wdata and rdwr stable until host_gnt.
- Core contract: the core holds its request while core_stall = 1.

Optional Feature:
ARB_STATS_EN
- Defined:
  - Adds output stall_cnt [15:0], which counts cycles with core_stall = 1.
  - Adds output force_cnt [7:0], which counts starvation-forced host wins.
  - Both counters saturate, and both clear on reset.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Core-only path: core read addr 4'h3, mem_rdata = 8'hA5 -> mem_en = 1, mem_we = 0 at cycle N; core_rvalid = 1 with core_rdata = 8'hA5 at N+1; core_stall = 0 throughout.
- Contention: core_en and host_req both held high -> core wins 4 cycles, host_gnt = 1 on cycle 5 with core_stall = 1 that cycle, wait_cnt then clears.
- Host burst: host_lock = 1 with writes to addr 0..9 -> 8 grants, then a REL cycle with the core served if requesting, then the host resumes.
- Alternating reads: host read 4'h1 then core read 4'h2 on consecutive cycles -> host_rvalid at N+1 and core_rvalid at N+2, each with the correct data.
- Reset during LOCK at burst_cnt = 3 -> all outputs 0 immediately, no rvalid after release, state returns to IDLE.
- ARB_STATS_EN defined with the contention scenario repeated 3 times -> stall_cnt = 3, force_cnt = 3.
